// File: rtl/block_sample_unpacker.sv
// Buffers whole deciphered blocks and plays them out one signed word per sample tick.
// Underruns are filled with SILENCE or with the last word played, selected by hold_mode_in.
module block_sample_unpacker #(
  parameter int                WORD_W  = 8,
  parameter int                N_WORDS = 16,
  parameter int                DEPTH   = 2,
  parameter logic [WORD_W-1:0] SILENCE = '0
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         block_valid_in,
  input  logic [N_WORDS*WORD_W-1:0]    block_in,
  output logic                         block_ready_out,
  input  logic                         tick_in,
  input  logic                         hold_mode_in,
  output logic [WORD_W-1:0]            word_out,
  output logic                         word_valid_out,
  output logic                         overflow_out,
  output logic                         underrun_out,
  output logic [$clog2(DEPTH+1)-1:0]   level_out
);

  localparam int BLK_W = N_WORDS * WORD_W;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int LVL_W = $clog2(DEPTH + 1);

  typedef enum logic {EMPTY, PLAY} state_t;

  state_t state;

  logic [BLK_W-1:0]  store_mem [DEPTH];
  logic [WORD_W-1:0] rd_words  [N_WORDS];

  logic [LVL_W-1:0]  occ_reg, occ_next;
  logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [WORD_W-1:0] word_reg, word_next;
  logic              valid_reg, valid_next;
  logic              overflow_reg, overflow_next;
  logic              underrun_reg, underrun_next;
  logic              push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Room is judged from occupancy at the start of the cycle; a same-cycle pop does not free a slot.
  assign block_ready_out = (occ_reg < LVL_W'(DEPTH));
  assign push            = block_valid_in && block_ready_out;

  always_comb state = (occ_reg == '0) ? EMPTY : PLAY;

  genvar gi;
  generate
    for (gi = 0; gi < N_WORDS; gi++) begin : g_word_view
      assign rd_words[gi] = store_mem[rd_ptr_reg][gi*WORD_W +: WORD_W];
    end
  endgenerate

  always_comb begin
    rd_ptr_next   = rd_ptr_reg;
    idx_next      = idx_reg;
    word_next     = word_reg;
    valid_next    = tick_in;
    underrun_next = 1'b0;
    overflow_next = block_valid_in && !block_ready_out;
    pop           = 1'b0;

    case (state)
      EMPTY: begin
        // A block pushed this cycle is not yet visible, so this tick still underruns.
        if (tick_in) begin
          underrun_next = 1'b1;
          word_next     = hold_mode_in ? word_reg : SILENCE;
        end
      end
      PLAY: begin
        if (tick_in) begin
          word_next = rd_words[idx_reg];
          if (idx_reg == IDX_W'(N_WORDS - 1)) begin
            idx_next    = '0;
            rd_ptr_next = ptr_inc(rd_ptr_reg);
            pop         = 1'b1;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      default: ;
    endcase

    wr_ptr_next = push ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;

    case ({push, pop})
      2'b10:   occ_next = occ_reg + 1'b1;
      2'b01:   occ_next = occ_reg - 1'b1;
      default: occ_next = occ_reg;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      occ_reg      <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      idx_reg      <= '0;
      word_reg     <= SILENCE;
      valid_reg    <= 1'b0;
      overflow_reg <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      occ_reg      <= occ_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      idx_reg      <= idx_next;
      word_reg     <= word_next;
      valid_reg    <= valid_next;
      overflow_reg <= overflow_next;
      underrun_reg <= underrun_next;
    end
  end

  // Block store carries no reset: stale contents are unreachable once the pointers clear.
  always_ff @(posedge clk_in) begin
    if (push) begin
      store_mem[wr_ptr_reg] <= block_in;
    end
  end

  assign word_out       = word_reg;
  assign word_valid_out = valid_reg;
  assign overflow_out   = overflow_reg;
  assign underrun_out   = underrun_reg;
  assign level_out      = occ_reg;

endmodule

// File: tb/tb_block_sample_unpacker.sv
// Directed bench for block_sample_unpacker: a word-queue reference model feeds a scoreboard
// that is drained as the DUT emits words; a second instance covers a wider parameter set.
module tb_block_sample_unpacker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         bv, tick, hold;
  logic [127:0] blk;
  logic         ready, wvalid, ovf, under;
  logic [7:0]   word;
  logic [1:0]   level;

  logic         bv2, tick2;
  logic [127:0] blk2;
  logic         ready2, wvalid2, ovf2, under2;
  logic [15:0]  word2;
  logic [1:0]   level2;

  block_sample_unpacker dut (
    .clk_in(clk), .rst_in(rst), .block_valid_in(bv), .block_in(blk),
    .block_ready_out(ready), .tick_in(tick), .hold_mode_in(hold),
    .word_out(word), .word_valid_out(wvalid), .overflow_out(ovf),
    .underrun_out(under), .level_out(level)
  );

  block_sample_unpacker #(.WORD_W(16), .N_WORDS(8), .DEPTH(3)) dut2 (
    .clk_in(clk), .rst_in(rst), .block_valid_in(bv2), .block_in(blk2),
    .block_ready_out(ready2), .tick_in(tick2), .hold_mode_in(hold),
    .word_out(word2), .word_valid_out(wvalid2), .overflow_out(ovf2),
    .underrun_out(under2), .level_out(level2)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0]  mq[$];
  logic [7:0]  m_last;
  logic [8:0]  sbq[$];
  logic [15:0] q2[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_occ();
    return (mq.size() + 15) / 16;
  endfunction

  function automatic logic [127:0] mk(input logic [7:0] base);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[k*8 +: 8] = base + 8'(k);
    return r;
  endfunction

  function automatic logic [15:0] w2f(input int bb, input int k);
    return 16'h8000 | 16'(bb * 256 + k * 3);
  endfunction

  function automatic logic [127:0] mk2(input int bb);
    logic [127:0] r;
    for (int k = 0; k < 8; k++) r[k*16 +: 16] = w2f(bb, k);
    return r;
  endfunction

  // One clock of stimulus on the default instance; the model advances tick-before-push.
  task automatic step(input logic v, input logic [127:0] b, input logic t);
    int occ;
    occ = m_occ();
    chk("ready", ready, occ < 2);
    bv = v; blk = b; tick = t;
    if (t) begin
      if (mq.size() == 0) begin
        if (!hold) m_last = 8'h00;
        sbq.push_back({1'b1, m_last});
      end else begin
        m_last = mq.pop_front();
        sbq.push_back({1'b0, m_last});
      end
    end
    if (v && occ < 2)
      for (int k = 0; k < 16; k++) mq.push_back(b[k*8 +: 8]);
    @(posedge clk); #1;
    bv = 1'b0; tick = 1'b0;
    chk("word_valid", wvalid, t);
    chk("overflow", ovf, v && occ >= 2);
    chk("level", level, m_occ());
  endtask

  task automatic step2(input logic v, input logic [127:0] b, input logic t, input logic exp_ovf);
    bv2 = v; blk2 = b; tick2 = t;
    @(posedge clk); #1;
    bv2 = 1'b0; tick2 = 1'b0;
    chk("overflow2", ovf2, exp_ovf);
    chk("word_valid2", wvalid2, t);
  endtask

  always @(negedge clk) begin
    if (wvalid === 1'b1) begin
      chk("sb_has_entry", sbq.size() != 0, 1);
      if (sbq.size() != 0) begin
        logic [8:0] e;
        e = sbq.pop_front();
        chk("word", word, e[7:0]);
        chk("underrun", under, e[8]);
        $display("word=0x%02h underrun=%0d level=%0d", word, under, level);
      end
    end
  end

  always @(negedge clk) begin
    if (wvalid2 === 1'b1) begin
      chk("sb2_has_entry", q2.size() != 0, 1);
      if (q2.size() != 0) begin
        logic [15:0] e2;
        e2 = q2.pop_front();
        chk("word2", word2, e2);
        chk("underrun2", under2, 0);
        $display("word2=0x%04h level2=%0d", word2, level2);
      end
    end
  end

  initial begin
    rst = 1'b1; bv = 1'b0; blk = '0; tick = 1'b0; hold = 1'b0;
    bv2 = 1'b0; blk2 = '0; tick2 = 1'b0; m_last = 8'h00;
    #12;
    chk("rst_word", word, 8'h00);
    chk("rst_valid", wvalid, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_under", under, 0);
    chk("rst_ready", ready, 1);
    chk("rst_level", level, 0);
    chk("rst_level2", level2, 0);
    chk("rst_ready2", ready2, 1);
    @(posedge clk); #1;
    rst = 1'b0;

    repeat (3) step(1'b0, '0, 1'b1);

    step(1'b1, mk(8'h00), 1'b0);
    repeat (16) step(1'b0, '0, 1'b1);
    hold = 1'b1;
    step(1'b0, '0, 1'b1);

    step(1'b1, mk(8'h10), 1'b0);
    step(1'b1, mk(8'h80), 1'b0);
    step(1'b1, mk(8'hE0), 1'b0);
    chk("full_ready", ready, 0);
    repeat (32) step(1'b0, '0, 1'b1);

    step(1'b1, mk(8'h20), 1'b0);
    step(1'b1, mk(8'h30), 1'b0);
    repeat (15) step(1'b0, '0, 1'b1);
    step(1'b1, mk(8'h40), 1'b1);
    step(1'b1, mk(8'h50), 1'b1);
    repeat (31) step(1'b0, '0, 1'b1);

    step(1'b1, mk(8'h60), 1'b1);
    repeat (5) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    #2 rst = 1'b1;
    #1;
    chk("arst_word", word, 8'h00);
    chk("arst_valid", wvalid, 0);
    chk("arst_level", level, 0);
    chk("arst_ready", ready, 1);
    mq.delete();
    sbq.delete();
    m_last = 8'h00;
    #1 rst = 1'b0;
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    for (int bb = 0; bb < 4; bb++) step2(1'b1, mk2(bb), 1'b0, bb == 3);
    chk("level2_full", level2, 3);
    chk("ready2_full", ready2, 0);
    for (int bb = 0; bb < 3; bb++) begin
      for (int k = 0; k < 8; k++) begin
        q2.push_back(w2f(bb, k));
        step2(1'b0, '0, 1'b1, 1'b0);
      end
    end
    step2(1'b0, '0, 1'b0, 1'b0);
    chk("level2_drained", level2, 0);

    step(1'b0, '0, 1'b0);
    chk("sb_drained", sbq.size(), 0);
    chk("sb2_drained", q2.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
